// File: rtl/breathing_sequencer.sv
// Breathing-envelope sequencer for the RGB PWM path: preset select, triangular
// envelope FSM, duty scaling and glitch-free PWM on a shared counter.
module breathing_sequencer #(
   parameter int TICK_DIV   = 50000,
   parameter int ENV_MAX    = 255,
   parameter int HOLD_STEPS = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       auto_mode,
   input  logic [1:0] sw,
   input  logic [7:0] R_time_in,
   input  logic [7:0] G_time_in,
   input  logic [7:0] B_time_in,
   output logic [1:0] sel_out,
   output logic [7:0] R_duty,
   output logic [7:0] G_duty,
   output logic [7:0] B_duty,
   output logic       R_pwm,
   output logic       G_pwm,
   output logic       B_pwm,
   output logic [7:0] env_out,
   output logic [2:0] state_out,
   output logic       cycle_done
);
   localparam int TW = $clog2(TICK_DIV);
   localparam int HW = $clog2(HOLD_STEPS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
   localparam logic [7:0]    ENV_TOP   = 8'(ENV_MAX);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RISE    = 3'd1,
      HOLD_HI = 3'd2,
      FALL    = 3'd3,
      HOLD_LO = 3'd4
   } state_t;

   state_t        state_reg, state_next;
   logic [7:0]    env_reg, env_next;
   logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
   logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
   logic          cycle_done_reg, cycle_done_next;
   logic          tick;
   logic [1:0]    sw_meta_reg, sw_sync_reg;
   logic [1:0]    sel_reg, sel_next;
   logic [7:0]    pwm_cnt_reg;

   assign tick = (state_reg != IDLE) && (tick_cnt_reg == TICK_LAST);

   always_comb begin
      state_next      = state_reg;
      env_next        = env_reg;
      tick_cnt_next   = tick_cnt_reg;
      hold_cnt_next   = hold_cnt_reg;
      cycle_done_next = 1'b0;
      if (state_reg != IDLE)
         tick_cnt_next = tick ? '0 : tick_cnt_reg + 1'b1;
      if (!en) begin
         state_next    = IDLE;
         env_next      = 8'd0;
         tick_cnt_next = '0;
         hold_cnt_next = '0;
      end else begin
         case (state_reg)
            IDLE: state_next = RISE;
            RISE: if (tick) begin
               env_next = env_reg + 8'd1;
               if (env_reg + 8'd1 == ENV_TOP) begin
                  state_next    = HOLD_HI;
                  hold_cnt_next = '0;
               end
            end
            HOLD_HI: if (tick) begin
               if (hold_cnt_reg == HOLD_LAST) begin
                  state_next    = FALL;
                  hold_cnt_next = '0;
               end else
                  hold_cnt_next = hold_cnt_reg + 1'b1;
            end
            FALL: if (tick) begin
               env_next = env_reg - 8'd1;
               if (env_reg == 8'd1)
                  state_next = HOLD_LO;
            end
            HOLD_LO: if (tick) begin
               if (hold_cnt_reg == HOLD_LAST) begin
                  state_next      = RISE;
                  hold_cnt_next   = '0;
                  cycle_done_next = 1'b1;
               end else
                  hold_cnt_next = hold_cnt_reg + 1'b1;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Manual mode tracks the switches continuously; auto mode steps once per breath.
   assign sel_next = !auto_mode      ? sw_sync_reg :
                     cycle_done_next ? sel_reg + 2'd1 : sel_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         env_reg        <= 8'd0;
         tick_cnt_reg   <= '0;
         hold_cnt_reg   <= '0;
         cycle_done_reg <= 1'b0;
         sw_meta_reg    <= 2'd0;
         sw_sync_reg    <= 2'd0;
         sel_reg        <= 2'd0;
         pwm_cnt_reg    <= 8'd0;
      end else begin
         state_reg      <= state_next;
         env_reg        <= env_next;
         tick_cnt_reg   <= tick_cnt_next;
         hold_cnt_reg   <= hold_cnt_next;
         cycle_done_reg <= cycle_done_next;
         sw_meta_reg    <= sw;
         sw_sync_reg    <= sw_meta_reg;
         sel_reg        <= sel_next;
         pwm_cnt_reg    <= (pwm_cnt_reg == 8'd254) ? 8'd0 : pwm_cnt_reg + 8'd1;
      end
   end

   logic [7:0] time_in [3];
   logic [7:0] duty_reg [3];
   logic [7:0] shadow_reg [3];
   logic       pwm_reg [3];
   logic [8:0] env_plus;

   assign time_in[0] = R_time_in;
   assign time_in[1] = G_time_in;
   assign time_in[2] = B_time_in;
   assign env_plus   = {1'b0, env_reg} + 9'd1;

   for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [15:0] prod;
      logic [7:0]  duty_eff;

      // env+1 makes the peak envelope pass time_in through unchanged.
      assign prod     = {8'd0, time_in[gi]} * {7'd0, env_plus};
      assign duty_eff = (pwm_cnt_reg == 8'd0) ? duty_reg[gi] : shadow_reg[gi];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            duty_reg[gi]   <= 8'd0;
            shadow_reg[gi] <= 8'd0;
            pwm_reg[gi]    <= 1'b0;
         end else begin
            duty_reg[gi]   <= (state_reg == IDLE) ? 8'd0 : 8'(prod >> 8);
            shadow_reg[gi] <= duty_eff;
            pwm_reg[gi]    <= pwm_cnt_reg < duty_eff;
         end
      end
   end

   assign sel_out    = sel_reg;
   assign env_out    = env_reg;
   assign state_out  = state_reg;
   assign cycle_done = cycle_done_reg;
   assign R_duty     = duty_reg[0];
   assign G_duty     = duty_reg[1];
   assign B_duty     = duty_reg[2];
   assign R_pwm      = pwm_reg[0];
   assign G_pwm      = pwm_reg[1];
   assign B_pwm      = pwm_reg[2];
endmodule

// File: tb/tb_breathing_sequencer.sv
// Bench for breathing_sequencer: two parameterisations side by side, a per-clock
// reference model, a hand-derived vector table and targeted corner sequences.
module tb_breathing_sequencer;
   localparam int TD_A = 4, EM_A = 3,   HS_A = 2;
   localparam int TD_B = 2, EM_B = 255, HS_B = 600;

   logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, auto_mode = 1'b1;
   logic [1:0] sw = 2'd0;
   logic [7:0] r_t = 8'd0, g_t = 8'd0, b_t = 8'd0;

   logic [1:0] sel_a, sel_b;
   logic [7:0] rd_a, gd_a, bd_a, rd_b, gd_b, bd_b, env_a, env_b;
   logic       rp_a, gp_a, bp_a, rp_b, gp_b, bp_b, cd_a, cd_b;
   logic [2:0] st_a, st_b;

   breathing_sequencer #(.TICK_DIV(TD_A), .ENV_MAX(EM_A), .HOLD_STEPS(HS_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .auto_mode(auto_mode), .sw(sw),
      .R_time_in(r_t), .G_time_in(g_t), .B_time_in(b_t), .sel_out(sel_a),
      .R_duty(rd_a), .G_duty(gd_a), .B_duty(bd_a), .R_pwm(rp_a), .G_pwm(gp_a), .B_pwm(bp_a),
      .env_out(env_a), .state_out(st_a), .cycle_done(cd_a));

   breathing_sequencer #(.TICK_DIV(TD_B), .ENV_MAX(EM_B), .HOLD_STEPS(HS_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .auto_mode(auto_mode), .sw(sw),
      .R_time_in(r_t), .G_time_in(g_t), .B_time_in(b_t), .sel_out(sel_b),
      .R_duty(rd_b), .G_duty(gd_b), .B_duty(bd_b), .R_pwm(rp_b), .G_pwm(gp_b), .B_pwm(bp_b),
      .env_out(env_b), .state_out(st_b), .cycle_done(cd_b));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: position in the breath is derived from clocks since leaving IDLE.
   int p_td [2] = '{TD_A, TD_B};
   int p_em [2] = '{EM_A, EM_B};
   int p_hs [2] = '{HS_A, HS_B};
   int m_run [2], m_st [2], m_env [2], m_sel [2], m_cd [2];
   int m_duty [2][3], m_pd [2][3], m_pwm [2][3];
   int m_sw1, m_sw2, m_n;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_run[i] = -1; m_st[i] = 0; m_env[i] = 0; m_sel[i] = 0; m_cd[i] = 0;
         for (int c = 0; c < 3; c++) begin
            m_duty[i][c] = 0; m_pd[i][c] = 0; m_pwm[i][c] = 0;
         end
      end
      m_sw1 = 0; m_sw2 = 0; m_n = 0;
   endtask

   task automatic phase(input int i);
      int k, len, c, em, hs;
      em = p_em[i]; hs = p_hs[i];
      len = 2 * em + 2 * hs;
      if (m_run[i] < 0) begin
         m_st[i] = 0; m_env[i] = 0;
      end else begin
         k = m_run[i] / p_td[i];
         c = k % len;
         if (c < em)                begin m_st[i] = 1; m_env[i] = c; end
         else if (c < em + hs)      begin m_st[i] = 2; m_env[i] = em; end
         else if (c < 2 * em + hs)  begin m_st[i] = 3; m_env[i] = 2 * em + hs - c; end
         else                       begin m_st[i] = 4; m_env[i] = 0; end
      end
      m_cd[i] = (m_run[i] > 0 && m_run[i] % (p_td[i] * len) == 0) ? 1 : 0;
   endtask

   task automatic model_edge();
      int tv [3];
      int pos;
      tv[0] = int'(r_t); tv[1] = int'(g_t); tv[2] = int'(b_t);
      pos = m_n % 255;
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < 3; c++) begin
            if (pos == 0) m_pd[i][c] = m_duty[i][c];
            m_pwm[i][c]  = (pos < m_pd[i][c]) ? 1 : 0;
            m_duty[i][c] = (m_st[i] == 0) ? 0 : (tv[c] * (m_env[i] + 1)) / 256;
         end
         m_run[i] = !en ? -1 : (m_run[i] < 0 ? 0 : m_run[i] + 1);
         phase(i);
         if (!auto_mode) m_sel[i] = m_sw2;
         else if (m_cd[i] != 0) m_sel[i] = (m_sel[i] + 1) % 4;
      end
      m_sw2 = m_sw1; m_sw1 = int'(sw); m_n++;
   endtask

   task automatic cmp(input int i, input logic [2:0] st, input logic [7:0] env,
                      input logic [1:0] sel, input logic cd, input logic [7:0] rd,
                      input logic [7:0] gd, input logic [7:0] bd, input logic rp,
                      input logic gp, input logic bp);
      string p;
      p = (i == 0) ? "A" : "B";
      check({p, " state"}, 32'(st), m_st[i]);
      check({p, " env"}, 32'(env), m_env[i]);
      check({p, " sel"}, 32'(sel), m_sel[i]);
      check({p, " cycle_done"}, 32'(cd), m_cd[i]);
      check({p, " R_duty"}, 32'(rd), m_duty[i][0]);
      check({p, " G_duty"}, 32'(gd), m_duty[i][1]);
      check({p, " B_duty"}, 32'(bd), m_duty[i][2]);
      check({p, " R_pwm"}, 32'(rp), m_pwm[i][0]);
      check({p, " G_pwm"}, 32'(gp), m_pwm[i][1]);
      check({p, " B_pwm"}, 32'(bp), m_pwm[i][2]);
   endtask

   task automatic compare_all();
      cmp(0, st_a, env_a, sel_a, cd_a, rd_a, gd_a, bd_a, rp_a, gp_a, bp_a);
      cmp(1, st_b, env_b, sel_b, cd_b, rd_b, gd_b, bd_b, rp_b, gp_b, bp_b);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   typedef struct {
      logic       en;
      logic       auto_m;
      logic [1:0] sw;
      int         nclk;
      int         st;
      int         env;
      int         sel;
      int         cd;
      int         gd;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int hi, n;
      tbl[0] = '{1'b1, 1'b1, 2'd0, 1, 1, 0, 0, 0, 0};
      tbl[1] = '{1'b1, 1'b1, 2'd0, 4, 1, 1, 0, 0, 0};
      tbl[2] = '{1'b1, 1'b1, 2'd0, 4, 1, 2, 0, 0, 1};
      tbl[3] = '{1'b1, 1'b1, 2'd0, 4, 2, 3, 0, 0, 2};
      tbl[4] = '{1'b1, 1'b1, 2'd0, 8, 3, 3, 0, 0, 3};
      tbl[5] = '{1'b1, 1'b1, 2'd0, 4, 3, 2, 0, 0, 3};
      tbl[6] = '{1'b1, 1'b1, 2'd0, 8, 4, 0, 0, 0, 1};
      tbl[7] = '{1'b1, 1'b1, 2'd0, 7, 4, 0, 0, 0, 0};
      tbl[8] = '{1'b1, 1'b1, 2'd0, 1, 1, 0, 1, 1, 0};
      tbl[9] = '{1'b1, 1'b1, 2'd0, 1, 1, 0, 1, 0, 0};

      r_t = 8'h7F; g_t = 8'hFF; b_t = 8'h33;
      model_reset();
      #12;
      compare_all();
      check("reset state", 32'(st_a), 0);
      rst_n = 1'b1;
      step(); step();

      // Breath timing from IDLE with the small parameter set.
      for (int v = 0; v < 10; v++) begin
         en = tbl[v].en; auto_mode = tbl[v].auto_m; sw = tbl[v].sw;
         repeat (tbl[v].nclk) step();
         check($sformatf("tbl%0d state", v), 32'(st_a), tbl[v].st);
         check($sformatf("tbl%0d env", v), 32'(env_a), tbl[v].env);
         check($sformatf("tbl%0d sel", v), 32'(sel_a), tbl[v].sel);
         check($sformatf("tbl%0d cycle_done", v), 32'(cd_a), tbl[v].cd);
         check($sformatf("tbl%0d G_duty", v), 32'(gd_a), tbl[v].gd);
      end

      repeat (118) step();
      check("auto sel before wrap", 32'(sel_a), 3);
      step();
      check("auto sel wrap", 32'(sel_a), 0);
      check("auto wrap cycle_done", 32'(cd_a), 1);

      repeat (95) step();
      check("scale env127", 32'(rd_b), 32'h3F);
      repeat (256) step();
      check("scale env255 R", 32'(rd_b), 32'h7F);
      check("scale env255 G", 32'(gd_b), 32'hFF);

      r_t = 8'h40;
      repeat (289) step();
      hi = 0;
      repeat (255) begin step(); hi += int'(rp_b); end
      check("pwm 0x40 width", hi, 64);
      r_t = 8'hFF;
      repeat (345) step();
      hi = 0;
      repeat (255) begin step(); hi += int'(rp_b); end
      check("pwm 0xFF width", hi, 255);

      auto_mode = 1'b0; sw = 2'b10;
      repeat (3) step();
      check("manual sel", 32'(sel_a), 2);
      n = 0;
      while (st_a != 3'd3 && n < 200) begin step(); n++; end
      check("reach FALL", 32'(st_a), 3);
      en = 1'b0;
      step();
      check("en off state", 32'(st_a), 0);
      check("en off env", 32'(env_a), 0);
      check("en off sel", 32'(sel_a), 2);

      en = 1'b1;
      step();
      auto_mode = 1'b1;
      n = 0;
      while (!cd_a && n < 100) begin step(); n++; end
      check("mode switch cycle_done", 32'(cd_a), 1);
      check("mode switch sel 3", 32'(sel_a), 3);
      step();
      n = 0;
      while (!cd_a && n < 100) begin step(); n++; end
      check("mode switch cycle_done 2", 32'(cd_a), 1);
      check("mode switch sel 0", 32'(sel_a), 0);

      n = 0;
      while (!(st_a == 3'd1 && env_a != 8'd0) && n < 100) begin step(); n++; end
      check("reach RISE", 32'(st_a), 1);
      #3 rst_n = 1'b0;
      #1;
      check("async rst A lo", 32'({st_a, env_a, sel_a, cd_a, rp_a, gp_a, bp_a}), 0);
      check("async rst A duty", 32'({rd_a, gd_a, bd_a}), 0);
      check("async rst B lo", 32'({st_b, env_b, sel_b, cd_b, rp_b, gp_b, bp_b}), 0);
      model_reset();
      en = 1'b0;
      #3 rst_n = 1'b1;
      step();
      check("release idle state", 32'(st_a), 0);
      check("release idle env", 32'(env_a), 0);

      for (int it = 0; it < 3000; it++) begin
         en = ($urandom_range(0, 149) != 0);
         if ($urandom_range(0, 149) == 0) auto_mode = ~auto_mode;
         if ($urandom_range(0, 19) == 0) sw = 2'($urandom);
         if ($urandom_range(0, 31) == 0) r_t = 8'($urandom);
         if ($urandom_range(0, 31) == 0) g_t = 8'($urandom);
         if ($urandom_range(0, 31) == 0) b_t = 8'($urandom);
         if ($urandom_range(0, 1499) == 0) begin
            #2 rst_n = 1'b0;
            model_reset();
            #1 compare_all();
            #1 rst_n = 1'b1;
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/breathing_sequencer.md
Name: breathing_sequencer

Overview:
- Controller for the RGB PWM colour path.
- Generates the 2-bit preset select that drives the colour decoder, and takes back its three 8-bit R/G/B time values.
- Scales those values by a triangular breathing envelope, then drives three PWM outputs to the RGB LED.
- In auto mode it advances to the next colour preset at the end of every breath cycle; in manual mode it follows the switches.

Parameters:
- TICK_DIV, 50000: clocks per envelope step (legal range >= 2).
- ENV_MAX, 255: envelope peak value (legal range 1..255).
- HOLD_STEPS, 64: envelope steps spent in each hold state (legal range >= 1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  run enable; 0 forces IDLE.
- auto_mode  in  1  1 = cycle presets automatically, 0 = follow sw.
- sw  in  2  manual preset select; asynchronous to clk.
- R_time_in  in  8  red time value from the decoder.
- G_time_in  in  8  green time value from the decoder.
- B_time_in  in  8  blue time value from the decoder.
- sel_out  out  2  registered preset select to the decoder.
- R_duty  out  8  scaled red duty, registered.
- G_duty  out  8  scaled green duty, registered.
- B_duty  out  8  scaled blue duty, registered.
- R_pwm  out  1  red PWM output.
- G_pwm  out  1  green PWM output.
- B_pwm  out  1  blue PWM output.
- env_out  out  8  current envelope value.
- state_out  out  3  FSM state: IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4.
- cycle_done  out  1  one-clock pulse at end of each breath cycle.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM state IDLE; tick, hold and PWM counters 0; sw synchronizer flops 0.
- Tick generator:
  - Counts 0..TICK_DIV-1 while FSM is not IDLE; tick is a one-clock strobe at the terminal count.
  - Counter is held at 0 in IDLE.
- FSM (all transitions and envelope updates happen only on tick, except the exits to IDLE):
  - IDLE: env=0. Moves to RISE on the first clock with en=1.
  - RISE: env+=1 per tick. On the tick where env reaches ENV_MAX, go to HOLD_HI with hold count cleared.
  - HOLD_HI: after HOLD_STEPS ticks, go to FALL.
  - FALL: env-=1 per tick. On the tick where env reaches 0, go to HOLD_LO.
  - HOLD_LO: after HOLD_STEPS ticks, go to RISE and pulse cycle_done in that same clock.
  - en=0 in any state: go to IDLE on the next clock; env=0 and tick/hold counters cleared in that clock; sel_out holds its value.
  - en and rst_n are the only ways out of the sequence; the envelope never wraps (saturates by construction).
- Preset select:
  - sw passes through a 2-flop synchronizer.
  - auto_mode=0: sel_out <= synchronized sw every clock, in any state.
  - auto_mode=1: sel_out increments modulo 4 (3->0) in the clock cycle_done pulses; otherwise it holds.
  - Switching manual to auto: the sequence continues from the current sel_out.
- Scaling:
  - Computed every clock: duty = (time_in * (env+1)) >> 8, using a 16-bit product and keeping bits [15:8].
  - Output registered, so latency is 1 clock from env or time_in to the duty outputs.
  - env=255 gives duty=time_in exactly; env=0 gives duty=0.
  - In IDLE, duties are forced to 0.
- PWM:
  - Shared 8-bit counter runs 0..254 and wraps, giving a period of 255 clocks; it runs in all states.
  - Each channel has a shadow duty register, loaded from the duty output only when the counter equals 0, so duty changes are glitch-free.
  - pwm = 1 while counter < shadow.
  - Duty 0: always low. Duty 255: always high.
  - PWM outputs are registered.

Test Plan:
- Reset: assert rst_n=0 mid-RISE, asynchronous to clk -> all outputs 0 immediately. Release with en=0 -> state_out=0, env_out=0.
- Cycle timing: TICK_DIV=4, ENV_MAX=3, HOLD_STEPS=2, en=1, auto_mode=1, from reset -> env_out sequence 1,2,3,3,3,2,1,0 (one value per tick). cycle_done pulses exactly 40 clocks after leaving IDLE; sel_out goes 0->1 on that pulse and after four cycles returns 3->0.
- Scaling: ENV_MAX=255, R_time_in=0x7F. At env=255 -> R_duty=0x7F one clock later. At env=127 -> R_duty=0x3F. With G_time_in=0xFF at env=0 -> G_duty=0x00.
- PWM: hold R_duty at 0x40 -> R_pwm high for exactly 64 of every 255 clocks. Change duty mid-period -> new width appears only from the next counter==0. Duty 0xFF -> R_pwm constant 1.
- Manual mode: auto_mode=0, sw=2'b10 -> sel_out=2 within 3 clocks. Toggle en 1->0 in FALL -> state_out=0 and env_out=0 next clock, sel_out stays 2.
- Mode switch: auto_mode 0->1 with sel_out=2 -> next cycle_done gives sel_out=3, then 0.
